// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time loader. It parses a byte stream and writes its payload into
//   instruction memory, holding the CPU in reset until the load completes.
//   Stream format: a 16-bit big-endian word count N, followed by N words.
//   Each word is 4 bytes, most-significant byte first.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When this macro is defined, one trailing byte must equal the XOR of all
//   data bytes. A match completes the load and a mismatch raises err_o.
//
// Parameters
//   MEM_WORDS : instruction-memory capacity in 32-bit words (largest N accepted)
//   CNT_W     : width of the word-count header field
//
// Ports
//   clk_i        in   rising-edge clock
//   rst_i        in   synchronous, active-high reset
//   byte_i       in   stream byte
//   byte_valid_i in   byte_i is valid
//   byte_ready_o out  loader accepts byte_i this cycle
//   im_we_o      out  memory write strobe, one cycle per word
//   im_addr_o    out  word-aligned byte address of the write
//   im_data_o    out  word to write
//   cpu_rst_n_o  out  CPU reset, released only on a successful load
//   done_o       out  load completed successfully
//   err_o        out  load failed (sticky until rst_i)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned MEM_WORDS = 128,
   parameter int unsigned CNT_W     = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic        im_we_o,
   output logic [31:0] im_addr_o,
   output logic [31:0] im_data_o,
   output logic        cpu_rst_n_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      HDR_HI, HDR_LO, WORD, WRITE, DONE, ERR
`ifdef LOADER_CHECKSUM_EN
      , CHK
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;     // word count N
   logic [CNT_W-1:0] idx;     // index of the word being assembled / written
   logic [31:0]      shreg;   // word assembly register
   logic [1:0]       bcnt;    // bytes of the current word received so far
   logic [7:0]       csum;    // running XOR of data bytes

   logic             accept;
   logic [CNT_W-1:0] n_next;
   logic [31:0]      word_next;

   // byte_ready_o is registered, so a handshake is a plain AND with the
   // registered value.
   assign accept    = byte_valid_i & byte_ready_o;
   assign n_next    = {cnt[CNT_W-9:0], byte_i};
   assign word_next = {shreg[23:0], byte_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= HDR_HI;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         bcnt         <= '0;
         csum         <= '0;
         byte_ready_o <= 1'b0;
         im_we_o      <= 1'b0;
         im_addr_o    <= '0;
         im_data_o    <= '0;
         cpu_rst_n_o  <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         im_we_o <= 1'b0;
         case (state)
            // Ready is raised here on the first cycle after reset.
            HDR_HI: begin
               byte_ready_o <= 1'b1;
               if (accept) begin
                  cnt   <= CNT_W'(byte_i);
                  state <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (accept) begin
                  cnt <= n_next;
                  if (n_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= CHK;
`else
                     state        <= DONE;
                     byte_ready_o <= 1'b0;
                     done_o       <= 1'b1;
                     cpu_rst_n_o  <= 1'b1;
`endif
                  end else if (32'(n_next) > MEM_WORDS) begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end else begin
                     state <= WORD;
                  end
               end
            end
            WORD: begin
               if (accept) begin
                  shreg <= word_next;
                  csum  <= csum ^ byte_i;
                  bcnt  <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     state        <= WRITE;
                     byte_ready_o <= 1'b0;
                     im_we_o      <= 1'b1;
                     im_addr_o    <= 32'({idx, 2'b00});
                     im_data_o    <= word_next;
                  end
               end
            end
            // One-cycle write slot. The index stops at N-1 and never wraps.
            WRITE: begin
               if (idx == cnt - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  state        <= CHK;
                  byte_ready_o <= 1'b1;
`else
                  state       <= DONE;
                  done_o      <= 1'b1;
                  cpu_rst_n_o <= 1'b1;
`endif
               end else begin
                  idx          <= idx + CNT_W'(1);
                  state        <= WORD;
                  byte_ready_o <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  if (byte_i == csum) begin
                     state        <= DONE;
                     byte_ready_o <= 1'b0;
                     done_o       <= 1'b1;
                     cpu_rst_n_o  <= 1'b1;
                  end else begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               byte_ready_o <= 1'b0;
            end
            // Drain mode: keep accepting bytes and drop them.
            ERR: begin
               byte_ready_o <= 1'b1;
               err_o        <= 1'b1;
               cpu_rst_n_o  <= 1'b0;
            end
            default: begin
               state <= HDR_HI;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. It sends fixed byte streams and compares
//   the write log and the status outputs against hand-computed values.
//   When LOADER_CHECKSUM_EN is defined it also covers the checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        cpu_rst_n;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] wa [8];
   logic [31:0] wd [8];
   int          wcnt = 0;
   logic [7:0]  stream [$];

   imem_loader #(.MEM_WORDS(128), .CNT_W(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .byte_i       (byte_in),
      .byte_valid_i (byte_valid),
      .byte_ready_o (byte_ready),
      .im_we_o      (im_we),
      .im_addr_o    (im_addr),
      .im_data_o    (im_data),
      .cpu_rst_n_o  (cpu_rst_n),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   // Write log, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && im_we) begin
         if (wcnt < 8) begin
            wa[wcnt] = im_addr;
            wd[wcnt] = im_data;
         end
         wcnt = wcnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input bit verify);
      @(negedge clk);
      rst        = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wcnt = 0;
      if (verify) begin
         chk("rst_ready",     32'(byte_ready), 32'd0);
         chk("rst_we",        32'(im_we),      32'd0);
         chk("rst_addr",      im_addr,         32'd0);
         chk("rst_data",      im_data,         32'd0);
         chk("rst_cpu_rst_n", 32'(cpu_rst_n),  32'd0);
         chk("rst_done",      32'(done),       32'd0);
         chk("rst_err",       32'(err),        32'd0);
      end
      rst = 1'b0;
   endtask

   // Present one byte and hold it until it is accepted (bounded wait).
   // With gap set, valid is held low across one clock edge first.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      if (gap) @(posedge clk);
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   task automatic send_stream(input bit gap);
      foreach (stream[i]) send_byte(stream[i], gap);
   endtask

   task automatic std_stream();
      stream = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                8'h9A, 8'hBC, 8'hDE, 8'hF0};
   endtask

   task automatic check_std_writes(input string p);
      chk({p, "_wcnt"},  32'(wcnt), 32'd2);
      chk({p, "_addr0"}, wa[0], 32'h0000_0000);
      chk({p, "_data0"}, wd[0], 32'h1234_5678);
      chk({p, "_addr1"}, wa[1], 32'h0000_0004);
      chk({p, "_data1"}, wd[1], 32'h9ABC_DEF0);
   endtask

   initial begin
      // Reset state, then ready comes up in HDR_HI
      do_reset(1'b1);
      @(negedge clk);
      chk("hdr_ready", 32'(byte_ready), 32'd1);

      // Two-word load; done follows the last write by one cycle
      std_stream();
      send_stream(1'b0);
      @(negedge clk);
      chk("a_we_last",   32'(im_we),      32'd1);
      chk("a_ready_wr",  32'(byte_ready), 32'd0);
      chk("a_done_early", 32'(done),      32'd0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      @(negedge clk);
      chk("a_done",      32'(done),       32'd1);
      chk("a_cpu_rst_n", 32'(cpu_rst_n),  32'd1);
      chk("a_err",       32'(err),        32'd0);
      chk("a_ready_done", 32'(byte_ready), 32'd0);
      check_std_writes("a");
      repeat (3) @(negedge clk);
      chk("a_done_hold", 32'(done), 32'd1);
      chk("a_no_extra",  32'(wcnt), 32'd2);

      // Oversized header: N=129 > 128
      do_reset(1'b0);
      stream = {8'h00, 8'h81};
      send_stream(1'b0);
      @(negedge clk);
      chk("b_err",       32'(err),        32'd1);
      chk("b_cpu_rst_n", 32'(cpu_rst_n),  32'd0);
      chk("b_ready",     32'(byte_ready), 32'd1);
      stream = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_stream(1'b0);
      repeat (2) @(negedge clk);
      chk("b_wcnt",      32'(wcnt),       32'd0);
      chk("b_err_hold",  32'(err),        32'd1);
      chk("b_done",      32'(done),       32'd0);

      // Boundary: N = MEM_WORDS is accepted
      do_reset(1'b0);
      stream = {8'h00, 8'h80};
      send_stream(1'b0);
      @(negedge clk);
      chk("c_err_max",   32'(err),        32'd0);
      chk("c_ready_max", 32'(byte_ready), 32'd1);

      // Empty load
      do_reset(1'b0);
      stream = {8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h00);
`endif
      send_stream(1'b0);
      @(negedge clk);
      chk("d_done",      32'(done),       32'd1);
      chk("d_cpu_rst_n", 32'(cpu_rst_n),  32'd1);
      chk("d_wcnt",      32'(wcnt),       32'd0);

      // Valid toggling every other cycle
      do_reset(1'b0);
      std_stream();
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h00);
`endif
      send_stream(1'b1);
      repeat (2) @(negedge clk);
      chk("e_done", 32'(done), 32'd1);
      check_std_writes("e");

      // Reset mid-word drops the partial word; a restart loads cleanly
      do_reset(1'b0);
      stream = {8'h00, 8'h02, 8'h12, 8'h34};
      send_stream(1'b0);
      do_reset(1'b0);
      chk("f_wcnt_rst", 32'(wcnt), 32'd0);
      chk("f_done_rst", 32'(done), 32'd0);
      std_stream();
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h00);
`endif
      send_stream(1'b0);
      repeat (2) @(negedge clk);
      chk("f_done", 32'(done), 32'd1);
      check_std_writes("f");

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum byte
      do_reset(1'b0);
      std_stream();
      stream.push_back(8'h01);
      send_stream(1'b0);
      @(negedge clk);
      chk("g_err",       32'(err),       32'd1);
      chk("g_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("g_done",      32'(done),      32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128, meaning the instruction-memory capacity in 32-bit words and the maximum accepted word count.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the word-count header field.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port byte_i  input  8  incoming stream byte.
REQ-006 SHALL have port byte_valid_i  input  1  byte_i is valid this cycle.
REQ-007 SHALL have port byte_ready_o  output  1  the loader accepts byte_i this cycle.
REQ-008 SHALL have port im_we_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr_o  output  32  byte address of the write; always word-aligned (bits [1:0]=0).
REQ-010 SHALL have port im_data_o  output  32  word to write.
REQ-011 SHALL have port cpu_rst_n_o  output  1  active-low reset to the CPU; low until the load completes successfully.
REQ-012 SHALL have port done_o  output  1  load completed successfully.
REQ-013 SHALL have port err_o  output  1  load failed; sticky until rst_i.

Function
REQ-014 SHALL accept a byte only on a clk_i edge where byte_valid_i=1 and byte_ready_o=1.
REQ-015 SHALL parse the stream as a big-endian word count N (2 bytes, high byte first), then N words of 4 bytes each, most-significant byte first.
REQ-016 SHALL use the states HDR_HI, HDR_LO, WORD, WRITE, DONE and ERR (plus CHK, see REQ-028).
REQ-017 SHALL make the following transitions: HDR_HI->HDR_LO on an accepted byte; HDR_LO->WORD on an accepted byte if 0<N<=MEM_WORDS; HDR_LO->DONE if N=0; HDR_LO->ERR if N>MEM_WORDS.
REQ-018 SHALL, in WORD, shift the accepted bytes into a 32-bit assembly register and enter WRITE after the 4th byte.
REQ-019 SHALL, in WRITE, assert im_we_o=1 and byte_ready_o=0 for exactly 1 cycle, with im_addr_o = 4*k for word index k (0-based) and im_data_o = the assembled word.
REQ-020 SHALL, after WRITE, return to WORD if k+1<N, otherwise enter DONE.
REQ-021 SHALL, therefore, have a latency of 1 cycle from acceptance of a word's 4th byte to its write strobe.
REQ-022 SHALL drive byte_ready_o=1 in HDR_HI, HDR_LO, WORD and ERR, and 0 in WRITE and DONE.
REQ-023 SHALL, in ERR, accept and discard every byte, hold cpu_rst_n_o=0 and err_o=1, and perform no writes.
REQ-024 SHALL, in DONE, hold done_o=1 and cpu_rst_n_o=1 until rst_i; DONE ignores all input.
REQ-025 SHALL keep im_we_o=0 in every state except WRITE.
REQ-026 SHALL not wrap the word index: the index never exceeds N-1, and N is bounded by MEM_WORDS.

Reset
REQ-027 SHALL, with rst_i=1 at a clk_i edge, enter HDR_HI and clear the index, the count and the assembly register to 0, with byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_n_o=0, done_o=0 and err_o=0; this holds mid-load, and any partial word is discarded.

Configuration
REQ-028 SHALL, with LOADER_CHECKSUM_EN defined, expect one trailing byte equal to the XOR of all 4*N data bytes: after the last WRITE (or after HDR_LO when N=0) the loader enters CHK with byte_ready_o=1, goes to DONE on a match and to ERR on a mismatch.
REQ-029 SHALL, with LOADER_CHECKSUM_EN undefined, have no CHK state and enter DONE directly as in REQ-017/REQ-020.

Verification
REQ-030 SHALL cover: stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> writes (0x0, 0x12345678) then (0x4, 0x9ABCDEF0); done_o=1 and cpu_rst_n_o=1 one cycle after the 2nd write.
REQ-031 SHALL cover: header 00 81 with MEM_WORDS=128 -> err_o=1, no im_we_o pulse, cpu_rst_n_o stays 0, and later bytes accepted and dropped.
REQ-032 SHALL cover: header 00 00 -> done_o=1 with no write (or, with the macro, after checksum byte 00).
REQ-033 SHALL cover: byte_valid_i toggled 1/0 every cycle during the REQ-030 stream -> identical writes, and no byte lost or duplicated.
REQ-034 SHALL cover: rst_i pulsed after 2 bytes of word 0 -> no write; a full restart of the REQ-030 stream then loads correctly.
REQ-035 SHALL cover, with LOADER_CHECKSUM_EN: the REQ-030 stream plus checksum 0x00 -> done_o=1; the same stream plus 0x01 -> err_o=1 and cpu_rst_n_o=0.
